// File: rtl/data_mem_bank_pkg.sv
// Shared types and helpers for the data memory bank.
package data_mem_pkg;

   // Access size codes carried on req_size.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Controller states: zero-fill sweep, then normal service.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Number of bytes touched by an access of the given size code.
   function automatic int byte_count(input logic [1:0] size);
      return 1 << size;
   endfunction

endpackage

// File: rtl/data_mem_bank_if.sv
// Request/response bus of the data memory bank.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the master keeps the request fields stable while
// req_valid is high. rsp_valid pulses for exactly one cycle, one cycle after
// the transfer edge, and is never back-pressured. rsp_rdata/rsp_err hold
// between pulses.
interface data_mem_bank_if #(
   parameter int ADDR_W     = 6,
   parameter int DATA_BYTES = 4
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [1:0]              req_size;
   logic                    req_signed;
   logic [ADDR_W-1:0]       req_addr;
   logic [8*DATA_BYTES-1:0] req_wdata;
   logic                    rsp_valid;
   logic [8*DATA_BYTES-1:0] rsp_rdata;
   logic                    rsp_err;
   logic                    busy;
   logic                    dbg_state;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, dbg_state
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, dbg_state
   );
endinterface

// File: rtl/data_mem_align.sv
// Byte-lane steering between the big-endian memory window and the
// right-aligned bus data. Lane i of win/wlane is the byte at address a+i,
// so lane 0 is the most significant byte of the access.
module data_mem_align
   import data_mem_pkg::*;
#(
   parameter int DATA_BYTES = 4
) (
   input  logic [1:0]              size,
   input  logic                    sign_ext,
   input  logic [8*DATA_BYTES-1:0] wdata,
   input  logic [8*DATA_BYTES-1:0] win,
   output logic [8*DATA_BYTES-1:0] wlane,
   output logic [DATA_BYTES-1:0]   lane_en,
   output logic [8*DATA_BYTES-1:0] rdata
);
   localparam int DW = 8 * DATA_BYTES;

   int   n_bytes;
   logic fill;

   // Steer store bytes onto lanes and right-align/extend load bytes.
   always_comb begin
      n_bytes = byte_count(size);
      // Invalid sizes are flagged upstream; clamp so indexing stays in range.
      if (n_bytes > DATA_BYTES) n_bytes = DATA_BYTES;
      fill    = sign_ext & win[7];
      wlane   = '0;
      lane_en = '0;
      rdata   = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i < n_bytes) begin
            lane_en[i]                     = 1'b1;
            wlane[8*i +: 8]                = wdata[8*(n_bytes-1-i) +: 8];
            rdata[8*(n_bytes-1-i) +: 8]    = win[8*i +: 8];
         end
      end
      for (int b = 0; b < DW; b++) begin
         if (b >= 8 * n_bytes) rdata[b] = fill;
      end
   end
endmodule

// File: rtl/data_mem_bank.sv
// Byte-addressed big-endian data memory with a valid/ready request port,
// registered single-cycle response and optional zero-fill after reset.
module data_mem_bank
   import data_mem_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int DATA_BYTES   = 4,
   parameter int ADDR_W       = 6,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input logic            clk,
   input logic            rst,
   data_mem_bank_if.slave bus
);
   localparam int DW     = 8 * DATA_BYTES;
   localparam int SZ_MAX = $clog2(DATA_BYTES);

   typedef logic [ADDR_W:0]   ext_addr_t;
   typedef logic [ADDR_W-1:0] ptr_t;

   localparam logic [0:0] S_CLEAR  = ST_CLEAR;
   localparam logic [0:0] S_READY  = ST_READY;
   localparam ext_addr_t  DEPTH_X  = ext_addr_t'(DEPTH);
   localparam ptr_t       LAST_PTR = ptr_t'(DEPTH - 1);

   logic [7:0]      mem [DEPTH];
   logic [0:0]      state;
   ptr_t            clr_ptr;
   logic            accept;
   logic            size_ok;
   logic            range_ok;
   logic            req_err;
   ext_addr_t       end_addr;
   ext_addr_t       lane_full [DATA_BYTES];
   ptr_t            lane_addr [DATA_BYTES];
   logic [DW-1:0]   win;
   logic [DW-1:0]   wlane;
   logic [DW-1:0]   load_data;
   logic [DATA_BYTES-1:0] lane_en;

   assign bus.busy      = (state == S_CLEAR);
   assign bus.req_ready = (state == S_READY);
   assign bus.dbg_state = state;

   // Reset wins over a request presented on the same edge.
   assign accept   = bus.req_valid && (state == S_READY) && !rst;
   assign size_ok  = int'(bus.req_size) <= SZ_MAX;
   // One extra bit so an access near the top cannot wrap to a small address.
   assign end_addr = {1'b0, bus.req_addr} + ext_addr_t'(byte_count(bus.req_size));
   assign range_ok = (end_addr <= DEPTH_X);
   assign req_err  = !size_ok || !range_ok;

   // Gather the DATA_BYTES-wide window starting at req_addr, MSB first.
   always_comb begin
      win = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         lane_full[i] = {1'b0, bus.req_addr} + ext_addr_t'(i);
         lane_addr[i] = lane_full[i][ADDR_W-1:0];
         if (lane_full[i] < DEPTH_X) win[8*i +: 8] = mem[lane_addr[i]];
      end
   end

   data_mem_align #(
      .DATA_BYTES (DATA_BYTES)
   ) u_align (
      .size     (bus.req_size),
      .sign_ext (bus.req_signed),
      .wdata    (bus.req_wdata),
      .win      (win),
      .wlane    (wlane),
      .lane_en  (lane_en),
      .rdata    (load_data)
   );

   // Byte array: zero-fill sweep, or commit an accepted in-range store.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_CLEAR) begin
            mem[clr_ptr] <= 8'h00;
         end else if (accept && bus.req_we && !req_err) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
               if (lane_en[i]) mem[lane_addr[i]] <= wlane[8*i +: 8];
            end
         end
      end
   end

   // Controller: sweep every byte once after reset, then serve requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR_ON_RST ? S_CLEAR : S_READY;
         clr_ptr <= '0;
      end else if (state == S_CLEAR) begin
         if (clr_ptr == LAST_PTR) state <= S_READY;
         clr_ptr <= clr_ptr + ptr_t'(1);
      end
   end

   // Response register: one pulse per accepted request, data held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else if (accept) begin
         bus.rsp_valid <= 1'b1;
         if (req_err) begin
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '1;
         end else begin
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= bus.req_we ? '0 : load_data;
         end
      end else begin
         bus.rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_data_mem_bank.sv
// Self-checking bench for data_mem_bank at default parameters.
module tb_data_mem_bank;
   import data_mem_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   logic [32:0] exp_q[$];
   logic [7:0]  model_mem [64];

   data_mem_bank_if #(.ADDR_W(6), .DATA_BYTES(4)) bus ();

   data_mem_bank #(
      .DEPTH(64), .DATA_BYTES(4), .ADDR_W(6), .CLEAR_ON_RST(1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: memory as a plain byte array, values as integers.
   function automatic logic [32:0] model_exec(input logic we, input logic [1:0] size,
                                              input logic sgn, input int addr,
                                              input logic [31:0] wdata);
      int n = 1 << size;
      logic [63:0] v;
      if (size > 2'd2 || addr + n > 64) return {1'b1, 32'hFFFF_FFFF};
      if (we) begin
         v = {32'd0, wdata};
         for (int i = n - 1; i >= 0; i--) begin
            model_mem[addr + i] = v[7:0];
            v = v >> 8;
         end
         return 33'd0;
      end
      v = 64'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | {56'd0, model_mem[addr + i]};
      if (sgn && v[8*n-1]) v = v - (64'd1 << (8 * n));
      return {1'b0, v[31:0]};
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
      exp_q.delete();
   endfunction

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      step();
   endtask

   task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [5:0] addr, input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      exp_q.push_back(model_exec(we, size, sgn, int'(addr), wdata));
      step();
   endtask

   // Tests
   task automatic test_reset();
      int busy_cycles = 0;
      int bad_ready   = 0;
      rst = 1'b1;
      step();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
      else n_pass++;
      n_checks++;
      if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h want 00000000", bus.rsp_rdata);
      else n_pass++;
      n_checks++;
      if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0)
         $display("FAIL reset_busy: got busy=%b ready=%b want busy=1 ready=0", bus.busy, bus.req_ready);
      else n_pass++;
      rst = 1'b0;
      for (int c = 0; c < 200 && bus.busy === 1'b1; c++) begin
         busy_cycles++;
         if (bus.req_ready !== 1'b0) bad_ready++;
         step();
      end
      n_checks++;
      if (busy_cycles != 64) $display("FAIL clear_length: got %0d busy cycles want 64", busy_cycles);
      else n_pass++;
      n_checks++;
      if (bad_ready != 0 || bus.req_ready !== 1'b1)
         $display("FAIL clear_ready: got %0d ready-while-busy cycles, ready after=%b want 0 and 1",
                  bad_ready, bus.req_ready);
      else n_pass++;
      model_clear();
      drive_req(1'b0, 2'd2, 1'b0, 6'd0, 32'h0);
      void'(exp_q.pop_front());
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0)
         $display("FAIL clear_load0: got valid=%b err=%b data=%h want 1 0 00000000",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      else n_pass++;
      idle();
   endtask

   task automatic test_misaligned();
      logic        we_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0]  sz_t [4] = '{2'd2, 2'd2, 2'd0, 2'd1};
      logic [5:0]  ad_t [4] = '{6'd5, 6'd5, 6'd6, 6'd7};
      logic [31:0] ex_t [4] = '{32'h0, 32'h1234_5678, 32'h0000_0034, 32'h0000_5678};
      for (int k = 0; k < 4; k++) begin
         drive_req(we_t[k], sz_t[k], 1'b0, ad_t[k], 32'h1234_5678);
         void'(exp_q.pop_front());
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== ex_t[k])
            $display("FAIL misaligned[%0d]: got valid=%b err=%b data=%h want 1 0 %h",
                     k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, ex_t[k]);
         else n_pass++;
      end
      idle();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) $display("FAIL misaligned_pulse: got valid=%b want 0", bus.rsp_valid);
      else n_pass++;
   endtask

   task automatic test_sign_ext();
      logic        we_t [3] = '{1'b1, 1'b0, 1'b0};
      logic        sg_t [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] ex_t [3] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080};
      for (int k = 0; k < 3; k++) begin
         drive_req(we_t[k], 2'd0, sg_t[k], 6'd10, 32'h0000_0080);
         void'(exp_q.pop_front());
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== ex_t[k])
            $display("FAIL sign_ext[%0d]: got valid=%b err=%b data=%h want 1 0 %h",
                     k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, ex_t[k]);
         else n_pass++;
      end
      idle();
   endtask

   task automatic test_range();
      logic        we_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0]  sz_t [6] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
      logic [5:0]  ad_t [6] = '{6'd60, 6'd61, 6'd61, 6'd61, 6'd63, 6'd63};
      logic        er_t [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ex_t [6] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};
      for (int k = 0; k < 6; k++) begin
         drive_req(we_t[k], sz_t[k], 1'b0, ad_t[k], 32'hAABB_CCDD);
         void'(exp_q.pop_front());
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== er_t[k] || bus.rsp_rdata !== ex_t[k])
            $display("FAIL range[%0d]: got valid=%b err=%b data=%h want 1 %b %h",
                     k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, er_t[k], ex_t[k]);
         else n_pass++;
      end
      idle();
   endtask

   task automatic test_invalid_size();
      logic        we_t [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sz_t [3] = '{2'd3, 2'd3, 2'd2};
      logic        er_t [3] = '{1'b1, 1'b1, 1'b0};
      logic [31:0] ex_t [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
      for (int k = 0; k < 3; k++) begin
         drive_req(we_t[k], sz_t[k], 1'b0, 6'd0, 32'hDEAD_BEEF);
         void'(exp_q.pop_front());
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== er_t[k] || bus.rsp_rdata !== ex_t[k])
            $display("FAIL invalid_size[%0d]: got valid=%b err=%b data=%h want 1 %b %h",
                     k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, er_t[k], ex_t[k]);
         else n_pass++;
      end
      idle();
   endtask

   task automatic test_random();
      logic [32:0] exp;
      logic [32:0] last = 33'd0;
      bit          have_last = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle();
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || (have_last && {bus.rsp_err, bus.rsp_rdata} !== last))
               $display("FAIL random_hold[%0d]: got valid=%b err/data=%h want 0 %h",
                        k, bus.rsp_valid, {bus.rsp_err, bus.rsp_rdata}, last);
            else n_pass++;
         end else begin
            drive_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || {bus.rsp_err, bus.rsp_rdata} !== exp)
               $display("FAIL random[%0d]: got valid=%b err/data=%h want 1 %h",
                        k, bus.rsp_valid, {bus.rsp_err, bus.rsp_rdata}, exp);
            else n_pass++;
            last      = exp;
            have_last = 1'b1;
         end
      end
      idle();
   endtask

   task automatic test_reset_mid_clear();
      int busy_cycles = 0;
      int bad_cycles  = 0;
      // Reset arriving together with a request drops the response.
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = 6'd0;
      rst = 1'b1;
      step();
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL reset_drop: got valid=%b busy=%b want 0 1", bus.rsp_valid, bus.busy);
      else n_pass++;
      rst = 1'b0;
      repeat (20) step();
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL mid_clear_busy: got busy=%b want 1", bus.busy);
      else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 200 && bus.busy === 1'b1; c++) begin
         busy_cycles++;
         if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) bad_cycles++;
         step();
      end
      n_checks++;
      if (busy_cycles != 64) $display("FAIL reclear_length: got %0d busy cycles want 64", busy_cycles);
      else n_pass++;
      n_checks++;
      if (bad_cycles != 0 || bus.rsp_valid !== 1'b0)
         $display("FAIL reclear_ignore: got %0d cycles with ready/rsp during clear, rsp now=%b want 0 0",
                  bad_cycles, bus.rsp_valid);
      else n_pass++;
      model_clear();
      step();
      bus.req_valid = 1'b0;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0)
         $display("FAIL held_accept: got valid=%b err=%b data=%h want 1 0 00000000",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      else n_pass++;
      step();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) $display("FAIL held_single: got valid=%b want 0", bus.rsp_valid);
      else n_pass++;
   endtask

   // Sequencer
   initial begin
      n_checks       = 0;
      n_pass         = 0;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      model_clear();
      test_reset();
      test_misaligned();
      test_sign_ext();
      test_range();
      test_invalid_size();
      test_random();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
